// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - sequential radix-2 Booth multiplier with register-bank writeback
module booth_mul_seq #(
  parameter int WIDTH   = 32,
  parameter int AW      = 4,
  parameter int WB_HIGH = 1
) (
  input  logic               clk,
  input  logic               reset_all,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [AW-1:0]      rd,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [AW-1:0]      wb_rd,
  output logic [WIDTH-1:0]   wb_data,
  output logic               wb_write,
  output logic               wb_enable
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_WB_LO,
    S_WB_HI,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH:0]   acc;
  logic             q_m1;
  logic [CW-1:0]    count;
  logic [AW-1:0]    rd_reg;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   acc_sum;
  logic [WIDTH:0]   acc_sh;
  logic [WIDTH-1:0] q_sh;

  // One Booth step: add/subtract the sign-extended multiplicand, then arithmetic shift right
  always_comb begin
    m_ext   = {m_reg[WIDTH-1], m_reg};
    acc_sum = acc;
    case ({q_reg[0], q_m1})
      2'b01:   acc_sum = acc + m_ext;
      2'b10:   acc_sum = acc - m_ext;
      default: acc_sum = acc;
    endcase
    acc_sh = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
    q_sh   = {acc_sum[0], q_reg[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clk or posedge reset_all) begin
    if (reset_all) state <= S_IDLE;
    else           state <= state_nx;
  end

  // Next-state logic; start is only honoured in IDLE so requests while busy are dropped
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_CALC;
      S_CALC:  if (count == CW'(1)) state_nx = S_WB_LO;
      S_WB_LO: state_nx = (WB_HIGH != 0) ? S_WB_HI : S_DONE;
      S_WB_HI: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand latch, Booth iteration and product capture on the final step
  always_ff @(posedge clk or posedge reset_all) begin
    if (reset_all) begin
      m_reg   <= '0;
      q_reg   <= '0;
      acc     <= '0;
      q_m1    <= 1'b0;
      count   <= '0;
      rd_reg  <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            m_reg  <= multiplicand;
            q_reg  <= multiplier;
            rd_reg <= rd;
            acc    <= '0;
            q_m1   <= 1'b0;
            count  <= CW'(WIDTH);
          end
        end
        S_CALC: begin
          acc   <= acc_sh;
          q_reg <= q_sh;
          q_m1  <= q_reg[0];
          count <= count - CW'(1);
          if (count == CW'(1)) product <= {acc_sh[WIDTH-1:0], q_sh};
        end
        default: ;
      endcase
    end
  end

  // Moore output decode; writeback only ever targets rd (low word) or rd+1 (high word)
  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    wb_write  = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    case (state)
      S_WB_LO: begin
        wb_write = 1'b1;
        wb_rd    = rd_reg;
        wb_data  = product[WIDTH-1:0];
      end
      S_WB_HI: begin
        wb_write = 1'b1;
        wb_rd    = rd_reg + AW'(1);
        wb_data  = product[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
    wb_enable = wb_write;
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb/tb_booth_mul_seq.sv - directed self-checking bench for booth_mul_seq
`timescale 1ns/1ps
module tb_booth_mul_seq;

  logic        clk = 1'b0;
  logic        reset_all = 1'b1;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [31:0] mcand = '0;
  logic [31:0] mplier = '0;
  logic [3:0]  rd = '0;

  logic        busy, done, wb_write, wb_enable;
  logic [63:0] product;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;

  logic        busy2, done2, wb_write2, wb_enable2;
  logic [63:0] product2;
  logic [3:0]  wb_rd2;
  logic [31:0] wb_data2;

  int total = 0;
  int bad = 0;
  int en_mis = 0;

  logic [3:0]  wq_idx[$];
  logic [31:0] wq_dat[$];
  logic [3:0]  wq2_idx[$];
  logic [31:0] wq2_dat[$];

  always #5 clk = ~clk;

  booth_mul_seq #(.WIDTH(32), .AW(4), .WB_HIGH(1)) dut (
    .clk(clk), .reset_all(reset_all), .start(start),
    .multiplicand(mcand), .multiplier(mplier), .rd(rd),
    .busy(busy), .done(done), .product(product),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_write(wb_write), .wb_enable(wb_enable)
  );

  booth_mul_seq #(.WIDTH(32), .AW(4), .WB_HIGH(0)) dut_lo (
    .clk(clk), .reset_all(reset_all), .start(start2),
    .multiplicand(mcand), .multiplier(mplier), .rd(rd),
    .busy(busy2), .done(done2), .product(product2),
    .wb_rd(wb_rd2), .wb_data(wb_data2), .wb_write(wb_write2), .wb_enable(wb_enable2)
  );

  // Record every bank write seen by either instance, sampled away from the active edge
  always @(negedge clk) begin
    if (wb_write) begin
      wq_idx.push_back(wb_rd);
      wq_dat.push_back(wb_data);
    end
    if (wb_write2) begin
      wq2_idx.push_back(wb_rd2);
      wq2_dat.push_back(wb_data2);
    end
    if (wb_enable !== wb_write || wb_enable2 !== wb_write2) en_mis++;
  end

  task automatic clear_q();
    wq_idx.delete(); wq_dat.delete(); wq2_idx.delete(); wq2_dat.delete();
  endtask

  // Issue one single-cycle start and follow the operation until busy falls (bounded)
  task automatic run_op(input logic [31:0] m, input logic [31:0] q, input logic [3:0] r,
                        input bit second, output int lat, output int ndone, output int first_wr);
    logic b, d, w;
    @(negedge clk);
    clear_q();
    mcand = m; mplier = q; rd = r;
    if (second) start2 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start2 = 1'b0;
    lat = -1; ndone = 0; first_wr = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      b = second ? busy2 : busy;
      d = second ? done2 : done;
      w = second ? wb_write2 : wb_write;
      if (d) begin
        ndone++;
        if (lat < 0) lat = n;
      end
      if (w && first_wr < 0) first_wr = n;
      if (!b) break;
    end
  endtask

  task automatic test_reset();
    reset_all = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (product !== 64'h0) begin bad++; $display("FAIL reset_product got=%h exp=0", product); end
    total++; if ({wb_write, wb_enable, wb_rd, wb_data} !== '0) begin bad++; $display("FAIL reset_wb got=%b%b %h %h exp=0", wb_write, wb_enable, wb_rd, wb_data); end
    @(negedge clk);
    reset_all = 1'b0;
  endtask

  task automatic test_basic();
    int lat, nd, fw;
    run_op(32'd7, 32'hFFFFFFFD, 4'd5, 1'b0, lat, nd, fw);
    total++; if (product !== 64'hFFFFFFFF_FFFFFFEB) begin bad++; $display("FAIL basic_product got=%h exp=ffffffffffffffeb", product); end
    total++; if (fw !== 32) begin bad++; $display("FAIL basic_calc_len got=%0d exp=32", fw); end
    total++; if (lat !== 34) begin bad++; $display("FAIL basic_done_latency got=%0d exp=34", lat); end
    total++; if (nd !== 1) begin bad++; $display("FAIL basic_done_width got=%0d exp=1", nd); end
    total++; if (wq_idx.size() !== 2) begin bad++; $display("FAIL basic_wr_count got=%0d exp=2", wq_idx.size()); end
    else begin
      total++; if (wq_idx[0] !== 4'd5 || wq_dat[0] !== 32'hFFFFFFEB) begin bad++; $display("FAIL basic_wr_lo got=%0d:%h exp=5:ffffffeb", wq_idx[0], wq_dat[0]); end
      total++; if (wq_idx[1] !== 4'd6 || wq_dat[1] !== 32'hFFFFFFFF) begin bad++; $display("FAIL basic_wr_hi got=%0d:%h exp=6:ffffffff", wq_idx[1], wq_dat[1]); end
    end
  endtask

  task automatic test_corners();
    int lat, nd, fw;
    run_op(32'h80000000, 32'h80000000, 4'd3, 1'b0, lat, nd, fw);
    total++; if (product !== 64'h40000000_00000000) begin bad++; $display("FAIL minmin_product got=%h exp=4000000000000000", product); end
    run_op(32'h80000000, 32'h00000001, 4'd3, 1'b0, lat, nd, fw);
    total++; if (product !== 64'hFFFFFFFF_80000000) begin bad++; $display("FAIL minone_product got=%h exp=ffffffff80000000", product); end
    total++; if (wq_dat.size() !== 2 || wq_dat[0] !== 32'h80000000 || wq_dat[1] !== 32'hFFFFFFFF) begin bad++; $display("FAIL minone_writes got_n=%0d exp=2 (80000000,ffffffff)", wq_dat.size()); end
    run_op(32'd123, 32'hFFFFFF85, 4'd7, 1'b0, lat, nd, fw);
    total++; if (product !== 64'hFFFFFFFF_FFFFC4E7) begin bad++; $display("FAIL neg_product got=%h exp=ffffffffffffc4e7", product); end
  endtask

  task automatic test_wrap();
    int lat, nd, fw;
    run_op(32'h12345678, 32'h0, 4'd15, 1'b0, lat, nd, fw);
    total++; if (product !== 64'h0) begin bad++; $display("FAIL wrap_product got=%h exp=0", product); end
    total++; if (wq_idx.size() !== 2) begin bad++; $display("FAIL wrap_wr_count got=%0d exp=2", wq_idx.size()); end
    else begin
      total++; if (wq_idx[0] !== 4'd15 || wq_dat[0] !== 32'h0) begin bad++; $display("FAIL wrap_wr_lo got=%0d:%h exp=15:0", wq_idx[0], wq_dat[0]); end
      total++; if (wq_idx[1] !== 4'd0 || wq_dat[1] !== 32'h0) begin bad++; $display("FAIL wrap_wr_hi got=%0d:%h exp=0:0", wq_idx[1], wq_dat[1]); end
    end
  endtask

  task automatic test_start_held();
    int low_at, low_cnt, high_at, nwr;
    @(negedge clk);
    clear_q();
    mcand = 32'd3; mplier = 32'd5; rd = 4'd1;
    start = 1'b1;
    @(posedge clk); #1;
    low_at = -1; low_cnt = 0; high_at = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (n == 10) begin mcand = 32'd100; mplier = 32'd100; rd = 4'd8; end
      if (!busy) begin low_cnt++; if (low_at < 0) low_at = n; end
      else if (low_at >= 0) begin high_at = n; break; end
    end
    start = 1'b0;
    nwr = wq_idx.size();
    total++; if (low_at !== 35 || low_cnt !== 1) begin bad++; $display("FAIL held_idle_gap got_at=%0d got_len=%0d exp=35/1", low_at, low_cnt); end
    total++; if (high_at !== 36) begin bad++; $display("FAIL held_restart got=%0d exp=36", high_at); end
    total++; if (product !== 64'd15) begin bad++; $display("FAIL held_product got=%h exp=f", product); end
    total++; if (nwr !== 2) begin bad++; $display("FAIL held_wr_count got=%0d exp=2", nwr); end
    else begin
      total++; if (wq_idx[0] !== 4'd1 || wq_dat[0] !== 32'd15 || wq_idx[1] !== 4'd2 || wq_dat[1] !== 32'd0) begin bad++; $display("FAIL held_wr got=%0d:%h %0d:%h exp=1:f 2:0", wq_idx[0], wq_dat[0], wq_idx[1], wq_dat[1]); end
    end
    for (int n = 0; n < 60 && busy; n++) begin @(posedge clk); #1; end
    total++; if (product !== 64'd10000) begin bad++; $display("FAIL held_second_product got=%h exp=2710", product); end
  endtask

  task automatic test_reset_mid();
    int lat, nd, fw;
    @(negedge clk);
    clear_q();
    mcand = 32'd5; mplier = 32'd5; rd = 4'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (22) @(posedge clk);
    #3 reset_all = 1'b1;
    #1;
    total++; if ({busy, done, wb_write} !== 3'b000) begin bad++; $display("FAIL rstmid_ctrl got=%b%b%b exp=000", busy, done, wb_write); end
    total++; if (product !== 64'h0) begin bad++; $display("FAIL rstmid_product got=%h exp=0", product); end
    @(negedge clk);
    reset_all = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    total++; if (wq_idx.size() !== 0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_no_wb got_writes=%0d busy=%b exp=0/0", wq_idx.size(), busy); end
    run_op(32'd6, 32'd7, 4'd9, 1'b0, lat, nd, fw);
    total++; if (product !== 64'd42) begin bad++; $display("FAIL rstmid_after_product got=%h exp=2a", product); end
    total++; if (wq_idx.size() !== 2 || wq_idx[0] !== 4'd9 || wq_dat[0] !== 32'd42) begin bad++; $display("FAIL rstmid_after_wr got_n=%0d exp=2 with 9:2a first", wq_idx.size()); end
  endtask

  task automatic test_wb_low_only();
    int lat, nd, fw;
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2, 1'b1, lat, nd, fw);
    total++; if (product2 !== 64'd1) begin bad++; $display("FAIL lo_product got=%h exp=1", product2); end
    total++; if (lat !== 33 || nd !== 1) begin bad++; $display("FAIL lo_done got_lat=%0d got_n=%0d exp=33/1", lat, nd); end
    total++; if (wq2_idx.size() !== 1) begin bad++; $display("FAIL lo_wr_count got=%0d exp=1", wq2_idx.size()); end
    else begin
      total++; if (wq2_idx[0] !== 4'd2 || wq2_dat[0] !== 32'd1) begin bad++; $display("FAIL lo_wr got=%0d:%h exp=2:1", wq2_idx[0], wq2_dat[0]); end
    end
    total++; if (wq_idx.size() !== 0) begin bad++; $display("FAIL lo_other_idle got=%0d exp=0", wq_idx.size()); end
  endtask

  task automatic test_enable();
    total++; if (en_mis !== 0) begin bad++; $display("FAIL enable_eq_write got=%0d exp=0", en_mis); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_wrap();
    test_start_held();
    test_reset_mid();
    test_wb_low_only();
    test_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Sequential radix-2 Booth multiplier that sits directly downstream of the register bank.
- Consumes the two operand read-port outputs and a destination index.
- Computes the signed 2*WIDTH-bit product.
- Writes the product back through the register bank write port: low word to rd, high word to rd+1.
- Start/busy/done handshake toward the controller.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH bits
AW, 4, register index width (16-entry bank)
WB_HIGH, 1, 1 = also write high word to rd+1; 0 = low-word writeback only

Ports:
clk  input  1  system clock; all state updates on posedge
reset_all  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
multiplicand  input  WIDTH  signed operand M (from bank out1)
multiplier  input  WIDTH  signed operand Q (from bank out2)
rd  input  AW  destination index, latched with operands
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
product  output  2*WIDTH  signed result, held until next accepted start
wb_rd  output  AW  bank write index
wb_data  output  WIDTH  bank write data
wb_write  output  1  bank write strobe
wb_enable  output  1  bank enable; equals wb_write

Behaviour:
- Reset (async, any state):
  - state = IDLE.
  - All outputs 0, including product.
  - Counter, accumulator and latched operands cleared.
  - No writeback is issued for the aborted operation.
- States: IDLE -> CALC -> WB_LO -> [WB_HI] -> DONE -> IDLE.
  - All outputs except product are Moore-decoded from the state register; no combinational path from inputs to outputs.
- IDLE, start=1 at posedge k:
  - Latch M, Q, rd.
  - acc = 0 (WIDTH+1 bits, sign-extended arithmetic); q_m1 = 0; count = WIDTH.
  - Go to CALC.
- CALC, one Booth step per posedge:
  - {Q[0],q_m1} = 01: acc += sext(M).
  - {Q[0],q_m1} = 10: acc -= sext(M).
  - 00 or 11: acc unchanged.
  - Then arithmetic right shift of {acc,Q,q_m1} by 1 (acc MSB replicated).
  - count decrements each step.
  - The step with count==1 is the last one (posedge k+WIDTH). On that edge, load product = {acc[WIDTH-1:0],Q} after the step and go to WB_LO.
- Accumulator width: WIDTH+1 bits so that M = -2^(WIDTH-1) cannot overflow. The product is exact for all signed operand pairs.
- WB_LO (one cycle): wb_write = wb_enable = 1, wb_rd = rd, wb_data = product[WIDTH-1:0]. The bank captures on the next posedge.
- WB_HI (one cycle, only if WB_HIGH=1): wb_rd = (rd+1) mod 2^AW, so 15 wraps to 0. wb_data = product[2*WIDTH-1:WIDTH].
- DONE (one cycle): done = 1, busy = 1, wb_write = 0. Then go to IDLE.
- Latency with WB_HIGH=1:
  - done high in the cycle following posedge k+WIDTH+2, i.e. the cycle after posedge k+34 for WIDTH=32.
  - The next start is accepted at posedge k+WIDTH+4 at earliest.
  - WB_HIGH=0 shortens this by one cycle.
- start while busy: ignored, with no queueing. Operand and rd inputs may change freely after the accepting edge.
- product is stable from WB_LO until the next accepted start, then updates only at the end of that operation's CALC.
- Writeback never targets any index other than rd or rd+1. The write strobe is never asserted in IDLE, CALC or DONE.

Test Plan:
- M=7, Q=-3, rd=5, start one cycle:
  - CALC lasts 32 cycles.
  - product = 0xFFFFFFFF_FFFFFFEB.
  - Writes reg5 = 0xFFFFFFEB, then reg6 = 0xFFFFFFFF.
  - done pulses exactly one cycle, 35 cycles after start.
- M=0x80000000, Q=0x80000000 -> product = 0x40000000_00000000. M=0x80000000, Q=1 -> 0xFFFFFFFF_80000000 (covers the overflow corner).
- M=0x12345678, Q=0, rd=15:
  - product = 0.
  - Writes reg15 = 0, then reg0 = 0 (index wrap).
- Start held high through a whole operation, operands changed mid-CALC:
  - The result matches only the operands latched at acceptance.
  - Exactly one writeback pair is issued.
  - A new operation begins only after returning to IDLE.
- reset_all asserted asynchronously mid-CALC (count=10):
  - busy, done, wb_write and product go to 0 immediately, with no writeback.
  - A following start of 6*7 yields 42, written to rd.
- WB_HIGH=0, M=-1, Q=-1, rd=2: product = 1, a single write of reg2 = 1, done 34 cycles after start.
